// File: rtl/seqdiv32.sv
// Sequential 32-bit signed radix-2 restoring divider: one quotient bit per clock, 34-cycle latency.
// Optional signed remainder output enabled by defining SEQDIV32_REMAINDER_EN.
module seqdiv32 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic        ctrl_DIV,
    output logic [31:0] out,
    output logic        ready,
    output logic        exception
`ifdef SEQDIV32_REMAINDER_EN
    ,
    output logic [31:0] remainder
`endif
);

    localparam int unsigned W   = 32;
    localparam int unsigned CW  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_bmag;
    logic            r_sa;
    logic            r_sb;
    logic [W-1:0]    r_out;
    logic            r_exc;
    logic            r_ready;
`ifdef SEQDIV32_REMAINDER_EN
    logic [W-1:0]    r_rem_out;
`endif

    logic [W-1:0]    w_amag;
    logic [W-1:0]    w_bmag;
    logic [W:0]      w_rem_sh;
    logic [W:0]      w_trial;

    // INT_MIN maps to itself, which reads correctly as an unsigned magnitude.
    assign w_amag   = A_in[W-1] ? W'(-A_in) : A_in;
    assign w_bmag   = B_in[W-1] ? W'(-B_in) : B_in;

    // Partial remainder stays below |B| <= 2^31, so the shifted value never needs more than 33 bits.
    assign w_rem_sh = {r_rem, r_q[W-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_bmag};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_bmag    <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_out     <= '0;
            r_exc     <= 1'b0;
            r_ready   <= 1'b0;
`ifdef SEQDIV32_REMAINDER_EN
            r_rem_out <= '0;
`endif
        end else begin
            r_ready <= 1'b0;
            // A start strobe wins in every state, silently aborting any division in flight.
            if (ctrl_DIV) begin
                r_sa   <= A_in[W-1];
                r_sb   <= B_in[W-1];
                r_q    <= w_amag;
                r_bmag <= w_bmag;
                r_rem  <= '0;
                r_cnt  <= '0;
                if (B_in == '0) begin
                    r_state   <= S_DONE;
                    r_out     <= '0;
                    r_exc     <= 1'b1;
`ifdef SEQDIV32_REMAINDER_EN
                    r_rem_out <= '0;
`endif
                end else begin
                    r_state <= S_RUN;
                end
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_RUN: begin
                        r_rem <= w_trial[W] ? w_rem_sh[W-1:0] : w_trial[W-1:0];
                        r_q   <= {r_q[W-2:0], ~w_trial[W]};
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(W - 1)) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        r_out     <= (r_sa ^ r_sb) ? W'(-r_q) : r_q;
                        r_exc     <= 1'b0;
`ifdef SEQDIV32_REMAINDER_EN
                        r_rem_out <= r_sa ? W'(-r_rem) : r_rem;
`endif
                        r_state   <= S_DONE;
                    end
                    S_DONE: begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign out       = r_out;
    assign ready     = r_ready;
    assign exception = r_exc;
`ifdef SEQDIV32_REMAINDER_EN
    assign remainder = r_rem_out;
`endif

endmodule

// File: tb/tb_seqdiv32.sv
// Directed bench for seqdiv32: vector table of signed divisions plus abort, back-to-back and reset sequences.
`timescale 1ns/1ps
module tb_seqdiv32;

    logic        clock;
    logic        reset_n;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        ctrl_DIV;
    logic [31:0] out;
    logic        ready;
    logic        exception;
`ifdef SEQDIV32_REMAINDER_EN
    logic [31:0] remainder;
`endif

    seqdiv32 dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .A_in      (A_in),
        .B_in      (B_in),
        .ctrl_DIV  (ctrl_DIV),
        .out       (out),
        .ready     (ready),
        .exception (exception)
`ifdef SEQDIV32_REMAINDER_EN
        ,
        .remainder (remainder)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
    } vec_t;

    vec_t vecs[14];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    // Drive a start strobe in the current cycle; returns #1 after start edge 0.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        A_in     = a;
        B_in     = b;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        A_in     = $urandom;
        B_in     = $urandom;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        launch(a, b);
    endtask

    // Count edges after edge 0 until ready is seen; -1 if the budget expires.
    task automatic wait_ready(output int lat);
        lat = -1;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clock);
            #1;
            if (ready) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;

    initial begin
        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        vecs[2]  = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
        vecs[3]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
        vecs[4]  = '{32'd5,          32'd0,          32'd0,          32'd0,          1'b1};
        vecs[5]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vecs[6]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vecs[7]  = '{32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0};
        vecs[8]  = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
        vecs[9]  = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[10] = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0};
        vecs[11] = '{32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0};
        vecs[12] = '{32'h80000000,   32'd7,          32'hEDB6DB6E,   32'hFFFFFFFE,   1'b0};
        vecs[13] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};

        reset_n  = 1'b0;
        ctrl_DIV = 1'b0;
        A_in     = '0;
        B_in     = '0;
        #23;
        chk("reset_out", out, 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_exc", 32'(exception), 32'd0);
`ifdef SEQDIV32_REMAINDER_EN
        chk("reset_rem", remainder, 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_ready(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].exc ? 32'd1 : 32'd34);
            chk($sformatf("v%0d_out", i), out, vecs[i].q);
            chk($sformatf("v%0d_exc", i), 32'(exception), 32'(vecs[i].exc));
`ifdef SEQDIV32_REMAINDER_EN
            if (!vecs[i].exc)
                chk($sformatf("v%0d_rem", i), remainder, vecs[i].r);
`endif
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_ready_pulse", i), 32'(ready), 32'd0);
        end

        // Exception stays held while the next division runs, then clears with its ready.
        start_op(32'd5, 32'd0);
        wait_ready(lat);
        chk("zero_latency", 32'(lat), 32'd1);
        start_op(32'd9, 32'd3);
        repeat (10) @(posedge clock);
        #1;
        chk("exc_held", 32'(exception), 32'd1);
        wait_ready(lat);
        chk("after_zero_latency", 32'(lat), 32'd24);
        chk("after_zero_out", out, 32'd3);
        chk("after_zero_exc", 32'(exception), 32'd0);

        // Back-to-back: start a new division during the ready cycle.
        start_op(32'd100, 32'd7);
        wait_ready(lat);
        chk("b2b_first_latency", 32'(lat), 32'd34);
        A_in     = 32'd81;
        B_in     = 32'd9;
        ctrl_DIV = 1'b1;
        #1;
        chk("b2b_old_out", out, 32'd14);
        chk("b2b_old_ready", 32'(ready), 32'd1);
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        chk("b2b_ready_drop", 32'(ready), 32'd0);
        wait_ready(lat);
        chk("b2b_second_latency", 32'(lat), 32'd34);
        chk("b2b_second_out", out, 32'd9);

        // Abort: 1000/3 restarted by 50/5 at edge 10; ready only after edge 44.
        start_op(32'd1000, 32'd3);
        repeat (9) @(posedge clock);
        #1;
        launch(32'd50, 32'd5);
        wait_ready(lat);
        chk("abort_latency", 32'(lat), 32'd34);
        chk("abort_out", out, 32'd10);
        chk("abort_exc", 32'(exception), 32'd0);

        // Reset at edge 20 of a division.
        start_op(32'd12345, 32'd67);
        repeat (20) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_out", out, 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_exc", 32'(exception), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_ready(lat);
        chk("midrst_no_ready", 32'(lat), 32'hFFFFFFFF);
        start_op(32'hFFFFFFAF, 32'd9);
        wait_ready(lat);
        chk("postrst_latency", 32'(lat), 32'd34);
        chk("postrst_out", out, 32'hFFFFFFF7);
`ifdef SEQDIV32_REMAINDER_EN
        chk("postrst_rem", remainder, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
